// File: rtl/rsa_pkg.sv
// ----------------------------------------------------------------------------
// rsa_pkg
// Shared types and constants for the RSA key-setup block.
//   status_t : result code returned with every key check
//   state_t  : control FSM states of rsa_key_setup
//   RSA_PW   : default width of the primes P and Q
// ----------------------------------------------------------------------------
package rsa_pkg;

    localparam int RSA_PW = 128;

    typedef enum logic [2:0] {
        STATUS_OK          = 3'd0,
        STATUS_PQ_SMALL    = 3'd1,
        STATUS_E_SMALL     = 3'd2,
        STATUS_E_LARGE     = 3'd3,
        STATUS_NOT_COPRIME = 3'd4,
        STATUS_TIMEOUT     = 3'd5
    } status_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL   = 3'd1,
        CHECK = 3'd2,
        GCD   = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/rsa_binary_gcd.sv
// ----------------------------------------------------------------------------
// rsa_binary_gcd
// Iterative binary GCD, one reduction step per clock.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   start_i      : load aInit_i/bInit_i and begin iterating
//   aInit_i      : first operand (the exponent E)
//   bInit_i      : second operand (the totient T)
//   done_o       : high for the one cycle in which the result is final
//   coprime_o    : with done_o, the operands reduced to gcd == 1
//   timeout_o    : with done_o, the iteration budget ran out
//   gcd_o        : with done_o, a|b on the zero exit, 0 on the both-even exit
// ----------------------------------------------------------------------------
module rsa_binary_gcd #(
    parameter int W        = 256,
    parameter int MAX_ITER = 1028
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_i,
    input  logic [W-1:0] aInit_i,
    input  logic [W-1:0] bInit_i,
    output logic         done_o,
    output logic         coprime_o,
    output logic         timeout_o,
    output logic [W-1:0] gcd_o
);

    localparam int IW = $clog2(MAX_ITER + 1);

    logic          active_q;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [IW-1:0] iter_q;

    logic          zeroExit;
    logic          bothEven;
    logic          lastIter;
    logic [W-1:0]  aOrB;

    // Exit conditions are combinational so the caller can leave on the same
    // edge that would have applied the step. Both-even means gcd >= 2, which
    // already proves the key bad, so the exact value is not worth chasing.
    always_comb begin
        aOrB      = a_q | b_q;
        zeroExit  = (a_q == '0) || (b_q == '0);
        bothEven  = !a_q[0] && !b_q[0];
        lastIter  = (iter_q == IW'(MAX_ITER - 1));
        done_o    = active_q && (zeroExit || bothEven || lastIter);
        timeout_o = active_q && !zeroExit && !bothEven && lastIter;
        coprime_o = zeroExit && (aOrB == W'(1));
        gcd_o     = zeroExit ? aOrB : '0;
    end

    // One reduction per cycle: strip a factor of two from whichever operand is
    // even, otherwise subtract the smaller from the larger (which makes the
    // difference even for the next cycle).
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (!zeroExit && !bothEven) begin
            if (!a_q[0]) begin
                a_d = a_q >> 1;
            end else if (!b_q[0]) begin
                b_d = b_q >> 1;
            end else if (a_q >= b_q) begin
                a_d = a_q - b_q;
            end else begin
                b_d = b_q - a_q;
            end
        end
    end

    // Operand and counter registers; a new start always wins so the caller
    // never has to wait for an idle handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            iter_q   <= '0;
        end else if (start_i) begin
            active_q <= 1'b1;
            a_q      <= aInit_i;
            b_q      <= bInit_i;
            iter_q   <= '0;
        end else if (active_q) begin
            a_q    <= a_d;
            b_q    <= b_d;
            iter_q <= iter_q + IW'(1);
            if (done_o) begin
                active_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rsa_key_setup.sv
// ----------------------------------------------------------------------------
// rsa_key_setup
// Computes N = P*Q and T = (P-1)*(Q-1), range-checks E and verifies
// gcd(E,T) == 1 before the key is released to the modexp datapath.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   start        : request a check (only sampled in IDLE)
//   p, q         : primes, PW bits
//   e            : public exponent, 2*PW bits
//   busy         : MUL/CHECK/GCD in progress
//   done         : one-cycle pulse, results final
//   key_valid    : status was OK; held until the next accepted start
//   status       : rsa_pkg::status_t code
//   n, t, gcd    : modulus, totient, computed gcd (held)
// ----------------------------------------------------------------------------
module rsa_key_setup
    import rsa_pkg::*;
#(
    parameter int PW       = RSA_PW,
    parameter int MAX_ITER = 8 * PW + 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [PW-1:0]   p,
    input  logic [PW-1:0]   q,
    input  logic [2*PW-1:0] e,
    output logic            busy,
    output logic            done,
    output logic            key_valid,
    output logic [2:0]      status,
    output logic [2*PW-1:0] n,
    output logic [2*PW-1:0] t,
    output logic [2*PW-1:0] gcd
);

    localparam int W = 2 * PW;

    state_t        state_q, state_d;
    status_t       status_q;
    logic [PW-1:0] pLat_q, qLat_q;
    logic [W-1:0]  eLat_q;
    logic [W-1:0]  nOut_q, tOut_q, gcdOut_q;
    logic          keyValid_q;

    logic [PW-1:0] pMinus1, qMinus1;
    logic [W-1:0]  nProd, tProd;
    status_t       rangeStatus;
    logic          rangeFail;
    logic          gcdStart, gcdDone, gcdCoprime, gcdTimeout;
    logic [W-1:0]  gcdValue;

    // The totient operands wrap in PW bits; a wrapped value only occurs for
    // P or Q < 1, which the range check rejects anyway.
    always_comb begin
        pMinus1 = pLat_q - PW'(1);
        qMinus1 = qLat_q - PW'(1);
        nProd   = W'(pLat_q) * W'(qLat_q);
        tProd   = W'(pMinus1) * W'(qMinus1);
    end

    // Range checks in priority order; T comes from the register loaded in MUL.
    always_comb begin
        rangeStatus = STATUS_OK;
        if ((pLat_q < PW'(2)) || (qLat_q < PW'(2))) begin
            rangeStatus = STATUS_PQ_SMALL;
        end else if (eLat_q <= W'(1)) begin
            rangeStatus = STATUS_E_SMALL;
        end else if (eLat_q >= tOut_q) begin
            rangeStatus = STATUS_E_LARGE;
        end
        rangeFail = (rangeStatus != STATUS_OK);
        gcdStart  = (state_q == CHECK) && !rangeFail;
    end

    rsa_binary_gcd #(
        .W        (W),
        .MAX_ITER (MAX_ITER)
    ) uGcd (
        .clk       (clk),
        .reset     (reset),
        .start_i   (gcdStart),
        .aInit_i   (eLat_q),
        .bInit_i   (tOut_q),
        .done_o    (gcdDone),
        .coprime_o (gcdCoprime),
        .timeout_o (gcdTimeout),
        .gcd_o     (gcdValue)
    );

    // Next-state logic; busy and done decode straight from the state so they
    // are exactly aligned with it and vanish the moment reset is applied.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE:  if (start) state_d = MUL;
            MUL:   begin busy = 1'b1; state_d = CHECK; end
            CHECK: begin busy = 1'b1; state_d = rangeFail ? DONE : GCD; end
            GCD:   begin busy = 1'b1; if (gcdDone) state_d = DONE; end
            DONE:  begin done = 1'b1; state_d = IDLE; end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Datapath registers. Previous results stay visible until MUL so a
    // consumer can still read them while the new request is being accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pLat_q     <= '0;
            qLat_q     <= '0;
            eLat_q     <= '0;
            nOut_q     <= '0;
            tOut_q     <= '0;
            gcdOut_q   <= '0;
            status_q   <= STATUS_OK;
            keyValid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (start) begin
                    pLat_q     <= p;
                    qLat_q     <= q;
                    eLat_q     <= e;
                    keyValid_q <= 1'b0;
                end
                MUL: begin
                    nOut_q   <= nProd;
                    tOut_q   <= tProd;
                    gcdOut_q <= '0;
                    status_q <= STATUS_OK;
                end
                CHECK: if (rangeFail) status_q <= rangeStatus;
                GCD: if (gcdDone) begin
                    gcdOut_q <= gcdValue;
                    if (gcdTimeout)      status_q <= STATUS_TIMEOUT;
                    else if (gcdCoprime) status_q <= STATUS_OK;
                    else                 status_q <= STATUS_NOT_COPRIME;
                end
                DONE: keyValid_q <= (status_q == STATUS_OK);
                default: ;
            endcase
        end
    end

    assign key_valid = keyValid_q;
    assign status    = status_q;
    assign n         = nOut_q;
    assign t         = tOut_q;
    assign gcd       = gcdOut_q;

endmodule
